// File: rtl/song_pkg.sv
// Shared types and constants for the song scheduler and the song ROM sequencers.
package song_pkg;

  localparam int NOTE_W = 5;
  localparam logic [NOTE_W-1:0] REST_NOTE = 5'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BGM  = 2'd1,
    SFX  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/beat_divider.sv
// Beat divider: counts 1..CLK_DIV and pulses tick on the last count of each beat.
module beat_divider #(
  parameter int CLK_DIV = 6000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] div_cnt;

  // Held at 1 while disabled or cleared so the next beat is always a full one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= CNT_ONE;
    end else if (clr || !en || (div_cnt == CNT_LAST)) begin
      div_cnt <= CNT_ONE;
    end else begin
      div_cnt <= div_cnt + CNT_ONE;
    end
  end

  assign tick = en && (div_cnt == CNT_LAST);

endmodule

// File: rtl/song_scheduler.sv
// Song scheduler: shares one note path between a BGM song and preempting SFX jingles.
//  state | meaning
//  IDLE  | silent, divider held, waiting for bgm_play or sfx_req
//  BGM   | stepping through the latched BGM song, one step per beat
//  SFX   | stepping through the latched SFX; BGM position parked in saved_step
module song_scheduler
  import song_pkg::*;
#(
  parameter int CLK_DIV = 6000000,
  parameter int STEP_W  = 7,
  parameter int SFX_LEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bgm_play,
  input  logic [1:0]        bgm_sel,
  input  logic              bgm_loop,
  input  logic              sfx_req,
  input  logic [1:0]        sfx_id,
  output logic [2:0]        rom_sel,
  output logic [STEP_W-1:0] rom_step,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [NOTE_W-1:0] note,
  output logic              beat_tick,
  output logic              sfx_active,
  output logic              sfx_done
);

  localparam logic [STEP_W-1:0] STEP_LAST = '1;
  localparam logic [STEP_W-1:0] SFX_LAST  = STEP_W'(SFX_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  sched_state_t      state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [STEP_W-1:0] saved_step, saved_nx;
  logic [1:0]        bgm_id, bgm_id_nx;
  logic [1:0]        sfx_id_q, sfx_id_nx;
  logic              tick;
  logic              div_clr;

  beat_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      saved_step <= '0;
      bgm_id     <= '0;
      sfx_id_q   <= '0;
      note       <= REST_NOTE;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      saved_step <= saved_nx;
      bgm_id     <= bgm_id_nx;
      sfx_id_q   <= sfx_id_nx;
      note       <= (state == IDLE) ? REST_NOTE : rom_note;
    end
  end

  // Branch order encodes edge priority: sfx_req > end-of-song > bgm_play change.
  always_comb begin
    state_nx  = state;
    step_nx   = step;
    saved_nx  = saved_step;
    bgm_id_nx = bgm_id;
    sfx_id_nx = sfx_id_q;
    sfx_done  = 1'b0;
    case (state)
      IDLE: begin
        if (sfx_req) begin
          state_nx  = SFX;
          step_nx   = '0;
          sfx_id_nx = sfx_id;
          bgm_id_nx = bgm_sel;
          saved_nx  = '0;
        end else if (bgm_play) begin
          state_nx  = BGM;
          step_nx   = '0;
          bgm_id_nx = bgm_sel;
        end
      end
      BGM: begin
        if (sfx_req) begin
          saved_nx  = step;
          state_nx  = SFX;
          step_nx   = '0;
          sfx_id_nx = sfx_id;
        end else if (tick && (step == STEP_LAST)) begin
          step_nx = '0;
          if (!bgm_loop) state_nx = IDLE;
        end else if (!bgm_play) begin
          state_nx = IDLE;
          step_nx  = '0;
        end else if (tick) begin
          step_nx = step + STEP_ONE;
        end
      end
      SFX: begin
        if (sfx_req) begin
          step_nx   = '0;
          sfx_id_nx = sfx_id;
        end else if (tick && (step == SFX_LAST)) begin
          sfx_done = 1'b1;
          if (bgm_play) begin
            state_nx = BGM;
            step_nx  = saved_step;
          end else begin
            state_nx = IDLE;
            step_nx  = '0;
          end
        end else if (tick) begin
          step_nx = step + STEP_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        step_nx  = '0;
      end
    endcase
  end

  // A restarted SFX gets a fresh full beat just like a state entry.
  assign div_clr    = (state_nx != state) || ((state == SFX) && sfx_req);
  assign beat_tick  = tick;
  assign sfx_active = (state == SFX);
  assign rom_sel    = {sfx_active, sfx_active ? sfx_id_q : bgm_id};
  assign rom_step   = step;

endmodule

// File: tb/tb_song_scheduler.sv
// Scoreboard bench for song_scheduler with a small behavioural ROM and event model.
module tb_song_scheduler;
  localparam int CLK_DIV = 4;
  localparam int STEP_W  = 3;
  localparam int SFX_LEN = 4;
  localparam int BGM_LEN = 1 << STEP_W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bgm_play = 1'b0;
  logic [1:0] bgm_sel = '0;
  logic       bgm_loop = 1'b0;
  logic       sfx_req = 1'b0;
  logic [1:0] sfx_id = '0;
  logic [2:0] rom_sel;
  logic [2:0] rom_step;
  logic [4:0] rom_note;
  logic [4:0] note;
  logic       beat_tick, sfx_active, sfx_done;

  song_scheduler #(.CLK_DIV(CLK_DIV), .STEP_W(STEP_W), .SFX_LEN(SFX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bgm_play(bgm_play), .bgm_sel(bgm_sel), .bgm_loop(bgm_loop),
    .sfx_req(sfx_req), .sfx_id(sfx_id), .rom_sel(rom_sel), .rom_step(rom_step),
    .rom_note(rom_note), .note(note), .beat_tick(beat_tick), .sfx_active(sfx_active),
    .sfx_done(sfx_done)
  );

  always #5 clk = ~clk;

  // ROM: {sel,step} truncated to 5 bits; one pair is reserved to read as silence.
  function automatic logic [4:0] rom_f(input logic [2:0] sel, input logic [2:0] st);
    logic [5:0] full;
    full = {sel, st};
    if (sel == 3'b101 && st == 3'd6) return 5'd25;
    return full[4:0];
  endfunction

  assign rom_note = rom_f(rom_sel, rom_step);

  typedef struct packed {
    logic [4:0] note;
    logic [2:0] sel;
    logic [2:0] step;
    logic       tick;
    logic       active;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model: mode 0 = silent, 1 = song, 2 = jingle; beat_left counts cycles left in the beat.
  int         m_mode = 0, m_pos = 0, m_saved = 0, m_left = CLK_DIV;
  logic [1:0] m_bgm = '0, m_sfx = '0;
  logic [4:0] m_note = 5'd25;

  task automatic enter(input int mode, input int pos);
    m_mode = mode;
    m_pos  = pos;
    m_left = CLK_DIV;
  endtask

  task automatic drive(input bit r, input bit p, input logic [1:0] s, input bit l,
                       input bit q, input logic [1:0] id);
    exp_t       e;
    bit         tk;
    logic [2:0] esel;
    logic [4:0] nn;
    @(negedge clk);
    rst_n = r; bgm_play = p; bgm_sel = s; bgm_loop = l; sfx_req = q; sfx_id = id;
    cyc++;
    tk   = (m_mode != 0) && (m_left == 1);
    esel = (m_mode == 2) ? {1'b1, m_sfx} : {1'b0, m_bgm};
    e.note   = m_note;
    e.sel    = esel;
    e.step   = 3'(m_pos);
    e.tick   = tk;
    e.active = (m_mode == 2);
    e.done   = (m_mode == 2) && tk && (m_pos == SFX_LEN - 1) && !q;
    e.busy   = (m_mode != 0);
    exp_q.push_back(e);
    nn = (m_mode == 0) ? 5'd25 : rom_f(esel, 3'(m_pos));
    if (!r) begin
      enter(0, 0);
      m_saved = 0;
      m_note  = 5'd25;
    end else begin
      m_note = nn;
      case (m_mode)
        0: begin
          if (q) begin m_sfx = id; m_bgm = s; m_saved = 0; enter(2, 0); end
          else if (p) begin m_bgm = s; enter(1, 0); end
        end
        1: begin
          if (q) begin m_saved = m_pos; m_sfx = id; enter(2, 0); end
          else if (tk && m_pos == BGM_LEN - 1) begin
            if (l) enter(1, 0); else enter(0, 0);
          end
          else if (!p) enter(0, 0);
          else if (tk) enter(1, m_pos + 1);
          else m_left--;
        end
        default: begin
          if (q) begin m_sfx = id; enter(2, 0); end
          else if (tk && m_pos == SFX_LEN - 1) begin
            if (p) enter(1, m_saved); else enter(0, 0);
          end
          else if (tk) enter(2, m_pos + 1);
          else m_left--;
        end
      endcase
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; pop and compare.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ok = (note === e.note) && (beat_tick === e.tick) && (sfx_active === e.active) &&
             (sfx_done === e.done);
        if (e.busy) ok = ok && (rom_sel === e.sel) && (rom_step === e.step);
        checks++;
        if (ok) passes++;
        else $display("FAIL outputs cyc %0d: got note=%0d sel=%b step=%0d tick=%b act=%b done=%b, want note=%0d sel=%b step=%0d tick=%b act=%b done=%b busy=%b",
                      cyc, note, rom_sel, rom_step, beat_tick, sfx_active, sfx_done,
                      e.note, e.sel, e.step, e.tick, e.active, e.done, e.busy);
      end
    end
  end

  initial begin
    bit         p, l, q, r;
    logic [1:0] s, id;
    // reset held with play requested, then BGM song 1 without loop
    repeat (3) drive(0, 1, 2'd1, 0, 0, 2'd0);
    repeat (34) drive(1, 1, 2'd1, 0, 0, 2'd0);
    repeat (6) drive(1, 0, 2'd1, 0, 0, 2'd0);
    // looping BGM over 20+ beats
    repeat (84) drive(1, 1, 2'd2, 1, 0, 2'd0);
    repeat (4) drive(1, 0, 2'd2, 0, 0, 2'd0);
    // SFX id 2 preempts mid step 5, BGM resumes
    repeat (22) drive(1, 1, 2'd0, 0, 0, 2'd0);
    drive(1, 1, 2'd0, 0, 1, 2'd2);
    repeat (30) drive(1, 1, 2'd0, 0, 0, 2'd0);
    // sfx_req together with play rise, then restart during SFX step 2
    repeat (4) drive(1, 0, 2'd3, 0, 0, 2'd0);
    drive(1, 1, 2'd3, 0, 1, 2'd1);
    repeat (9) drive(1, 1, 2'd3, 0, 0, 2'd0);
    drive(1, 1, 2'd3, 0, 1, 2'd0);
    repeat (40) drive(1, 1, 2'd3, 0, 0, 2'd0);
    // stop in BGM, then reset during SFX
    repeat (6) drive(1, 0, 2'd3, 0, 0, 2'd0);
    drive(1, 1, 2'd1, 0, 1, 2'd3);
    repeat (6) drive(1, 1, 2'd1, 0, 0, 2'd0);
    drive(0, 1, 2'd1, 0, 0, 2'd0);
    repeat (10) drive(1, 0, 2'd1, 0, 0, 2'd0);
    // randomized traffic
    p = 1; l = 0; s = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59) == 0) p = !p;
      if ($urandom_range(99) == 0) l = !l;
      if ($urandom_range(29) == 0) s = 2'($urandom_range(3));
      q  = ($urandom_range(39) == 0);
      id = 2'($urandom_range(3));
      r  = ($urandom_range(299) != 0);
      drive(r, p, s, l, q, id);
    end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
